// File: rtl/video_pattern_generator.sv
// Parametrised test-pattern source: one pixel per accepted VideoReady cycle,
// raster counters, four pattern modes and a palette of up to four colours.
module video_pattern_generator #(
    parameter int                     H_ACTIVE    = 800,
    parameter int                     V_ACTIVE    = 600,
    parameter int                     PIXEL_WIDTH = 24,
    parameter int                     BAR_LOG2    = 6,
    parameter int                     NUM_COLORS  = 2,
    parameter logic [PIXEL_WIDTH-1:0] COLOR0      = 24'h1ABC9C,
    parameter logic [PIXEL_WIDTH-1:0] COLOR1      = 24'hE67E22,
    parameter logic [PIXEL_WIDTH-1:0] COLOR2      = 24'hF1C40F,
    parameter logic [PIXEL_WIDTH-1:0] COLOR3      = 24'hC0392B
) (
    input  logic                   Clock,
    input  logic                   Reset_n,
    input  logic                   VideoReady,
    input  logic [1:0]             Mode,
    output logic [PIXEL_WIDTH-1:0] video,
    output logic                   StartOfFrame,
    output logic                   EndOfLine,
    output logic                   EndOfFrame,
    output logic [7:0]             FrameCount
);

    localparam int XW = $clog2(H_ACTIVE);
    localparam int YW = $clog2(V_ACTIVE);
    localparam int TW = (BAR_LOG2 > 0) ? BAR_LOG2 : 1;

    localparam logic [XW-1:0] X_LAST   = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_ACTIVE - 1);
    // A bar ends where the low BAR_LOG2 bits of the coordinate are all ones;
    // a mask wider than the counter only matches at the line/frame end.
    localparam logic [XW-1:0] X_MASK   = XW'((1 << BAR_LOG2) - 1);
    localparam logic [YW-1:0] Y_MASK   = YW'((1 << BAR_LOG2) - 1);
    localparam logic [TW-1:0] T_LAST   = TW'((1 << BAR_LOG2) - 1);
    localparam logic [1:0]    IDX_LAST = 2'(NUM_COLORS - 1);

    logic [XW-1:0]          r_x;
    logic [YW-1:0]          r_y;
    logic [TW-1:0]          r_tcnt;
    logic [1:0]             r_t_idx;
    logic [1:0]             r_x_bar;
    logic [1:0]             r_y_bar;
    logic                   r_x_tog;
    logic                   r_y_tog;
    logic [1:0]             r_mode;
    logic [7:0]             r_frame_cnt;

    logic                   w_eol;
    logic                   w_eof;
    logic                   w_x_edge;
    logic                   w_y_edge;
    logic [1:0]             w_color_idx;
    logic [PIXEL_WIDTH-1:0] w_pixel;

    function automatic logic [1:0] idx_inc(input logic [1:0] i);
        return (i == IDX_LAST) ? 2'd0 : i + 2'd1;
    endfunction

    assign w_eol    = (r_x == X_LAST);
    assign w_eof    = w_eol && (r_y == Y_LAST);
    assign w_x_edge = ((r_x & X_MASK) == X_MASK);
    assign w_y_edge = ((r_y & Y_MASK) == Y_MASK);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_x         <= '0;
            r_y         <= '0;
            r_tcnt      <= '0;
            r_t_idx     <= 2'd0;
            r_x_bar     <= 2'd0;
            r_y_bar     <= 2'd0;
            r_x_tog     <= 1'b0;
            r_y_tog     <= 1'b0;
            r_mode      <= 2'd0;
            r_frame_cnt <= 8'd0;
        end else if (VideoReady) begin
            // Temporal index runs across lines and frames, never cleared.
            if (r_tcnt == T_LAST) begin
                r_tcnt  <= '0;
                r_t_idx <= idx_inc(r_t_idx);
            end else begin
                r_tcnt  <= r_tcnt + 1'b1;
            end

            if (w_eol) begin
                r_x     <= '0;
                r_x_bar <= 2'd0;
                r_x_tog <= 1'b0;
                if (w_eof) begin
                    r_y         <= '0;
                    r_y_bar     <= 2'd0;
                    r_y_tog     <= 1'b0;
                    r_mode      <= Mode;
                    r_frame_cnt <= r_frame_cnt + 8'd1;
                end else begin
                    r_y <= r_y + 1'b1;
                    if (w_y_edge) begin
                        r_y_bar <= idx_inc(r_y_bar);
                        r_y_tog <= ~r_y_tog;
                    end
                end
            end else begin
                r_x <= r_x + 1'b1;
                if (w_x_edge) begin
                    r_x_bar <= idx_inc(r_x_bar);
                    r_x_tog <= ~r_x_tog;
                end
            end
        end
    end

    // Checkerboard reuses the palette path: index 0/1 selects COLOR0/COLOR1.
    always_comb begin
        w_color_idx = 2'd0;
        case (r_mode)
            2'd0:    w_color_idx = r_t_idx;
            2'd1:    w_color_idx = r_x_bar;
            2'd2:    w_color_idx = r_y_bar;
            default: w_color_idx = {1'b0, r_x_tog ^ r_y_tog};
        endcase
    end

    always_comb begin
        w_pixel = COLOR0;
        case (w_color_idx)
            2'd0:    w_pixel = COLOR0;
            2'd1:    w_pixel = COLOR1;
            2'd2:    w_pixel = COLOR2;
            default: w_pixel = COLOR3;
        endcase
    end

    assign video        = w_pixel;
    assign StartOfFrame = (r_x == '0) && (r_y == '0);
    assign EndOfLine    = w_eol;
    assign EndOfFrame   = w_eof;
    assign FrameCount   = r_frame_cnt;

endmodule

// File: tb/tb_video_pattern_generator.sv
// Bench for video_pattern_generator: directed table, hand-written frame
// sequences and randomized stalls/mode changes against a pixel-count model.
module tb_video_pattern_generator;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int B  = 1;
    localparam int N  = 3;
    localparam int PW = 24;
    localparam logic [PW-1:0] C0 = 24'h1ABC9C;
    localparam logic [PW-1:0] C1 = 24'hE67E22;
    localparam logic [PW-1:0] C2 = 24'hF1C40F;
    localparam logic [PW-1:0] C3 = 24'hC0392B;

    logic          Clock = 1'b0;
    logic          Reset_n;
    logic          VideoReady;
    logic [1:0]    Mode;
    logic [PW-1:0] video;
    logic          StartOfFrame;
    logic          EndOfLine;
    logic          EndOfFrame;
    logic [7:0]    FrameCount;

    video_pattern_generator #(
        .H_ACTIVE(H), .V_ACTIVE(V), .PIXEL_WIDTH(PW), .BAR_LOG2(B), .NUM_COLORS(N),
        .COLOR0(C0), .COLOR1(C1), .COLOR2(C2), .COLOR3(C3)
    ) dut (
        .Clock(Clock), .Reset_n(Reset_n), .VideoReady(VideoReady), .Mode(Mode),
        .video(video), .StartOfFrame(StartOfFrame), .EndOfLine(EndOfLine),
        .EndOfFrame(EndOfFrame), .FrameCount(FrameCount)
    );

    always #5 Clock = ~Clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: the whole raster state follows from the number of accepted
    // pixels since reset plus the mode latched for the current frame.
    int m_p    = 0;
    int m_mode = 0;

    function automatic logic [PW-1:0] pal(input int i);
        case (i)
            0:       return C0;
            1:       return C1;
            2:       return C2;
            default: return C3;
        endcase
    endfunction

    function automatic logic [PW-1:0] model_video();
        int x, y;
        x = m_p % H;
        y = (m_p / H) % V;
        case (m_mode)
            0:       return pal((m_p / (1 << B)) % N);
            1:       return pal((x / (1 << B)) % N);
            2:       return pal((y / (1 << B)) % N);
            default: return ((((x / (1 << B)) + (y / (1 << B))) % 2) == 1) ? C1 : C0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        int x, y;
        x = m_p % H;
        y = (m_p / H) % V;
        chk({tag, "_video"}, 32'(video), 32'(model_video()));
        chk({tag, "_sof"}, 32'(StartOfFrame), 32'((x == 0) && (y == 0)));
        chk({tag, "_eol"}, 32'(EndOfLine), 32'(x == H - 1));
        chk({tag, "_eof"}, 32'(EndOfFrame), 32'((x == H - 1) && (y == V - 1)));
        chk({tag, "_fc"}, 32'(FrameCount), 32'((m_p / (H * V)) % 256));
    endtask

    task automatic step(input logic rdy);
        VideoReady = rdy;
        @(posedge Clock);
        if (rdy) begin
            if ((m_p % (H * V)) == H * V - 1) m_mode = int'(Mode);
            m_p++;
        end
        #1;
    endtask

    // Reset is asserted away from any clock edge and checked before the next one.
    task automatic do_reset(input logic [1:0] mode_pre);
        Mode       = mode_pre;
        VideoReady = 1'b0;
        #2;
        Reset_n = 1'b0;
        m_p     = 0;
        m_mode  = 0;
        #1;
        chk("rst_video", 32'(video), 32'(C0));
        chk("rst_sof", 32'(StartOfFrame), 32'd1);
        chk("rst_eol", 32'(EndOfLine), 32'd0);
        chk("rst_eof", 32'(EndOfFrame), 32'd0);
        chk("rst_fc", 32'(FrameCount), 32'd0);
        @(negedge Clock);
        @(negedge Clock);
        Reset_n = 1'b1;
    endtask

    typedef struct {
        logic          rdy;
        logic [PW-1:0] v;
        logic          sof;
        logic          eol;
        logic [7:0]    fc;
    } vec_t;

    vec_t tbl[12];
    logic [PW-1:0] line_m1[8];
    logic [PW-1:0] line_m3[8];

    initial begin
        Reset_n    = 1'b1;
        VideoReady = 1'b0;
        Mode       = 2'd0;

        tbl[0]  = '{1'b1, C0, 1'b0, 1'b0, 8'd0};
        tbl[1]  = '{1'b0, C0, 1'b0, 1'b0, 8'd0};
        tbl[2]  = '{1'b0, C0, 1'b0, 1'b0, 8'd0};
        tbl[3]  = '{1'b1, C1, 1'b0, 1'b0, 8'd0};
        tbl[4]  = '{1'b1, C1, 1'b0, 1'b0, 8'd0};
        tbl[5]  = '{1'b1, C2, 1'b0, 1'b0, 8'd0};
        tbl[6]  = '{1'b1, C2, 1'b0, 1'b0, 8'd0};
        tbl[7]  = '{1'b1, C0, 1'b0, 1'b0, 8'd0};
        tbl[8]  = '{1'b1, C0, 1'b0, 1'b1, 8'd0};
        tbl[9]  = '{1'b0, C0, 1'b0, 1'b1, 8'd0};
        tbl[10] = '{1'b1, C1, 1'b0, 1'b0, 8'd0};
        tbl[11] = '{1'b1, C1, 1'b0, 1'b0, 8'd0};
        line_m1 = '{C0, C0, C1, C1, C2, C2, C0, C0};
        line_m3 = '{C0, C0, C1, C1, C0, C0, C1, C1};

        // Mode 0 with stalls: table of directed vectors.
        do_reset(2'd0);
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].rdy);
            chk($sformatf("vec%0d_video", i), 32'(video), 32'(tbl[i].v));
            chk($sformatf("vec%0d_sof", i), 32'(StartOfFrame), 32'(tbl[i].sof));
            chk($sformatf("vec%0d_eol", i), 32'(EndOfLine), 32'(tbl[i].eol));
            chk($sformatf("vec%0d_fc", i), 32'(FrameCount), 32'(tbl[i].fc));
        end
        while (m_p < 31) begin
            step(1'b1);
            chk_model("m0");
        end
        chk("m0_last_eof", 32'(EndOfFrame), 32'd1);
        step(1'b1);
        chk("m0_wrap_sof", 32'(StartOfFrame), 32'd1);
        chk("m0_wrap_fc", 32'(FrameCount), 32'd1);
        chk("m0_wrap_video", 32'(video), 32'(C1));

        // Mode 1 preset during reset: frame 0 still temporal, frame 1 bars.
        do_reset(2'd1);
        chk("m1_f0_p0", 32'(video), 32'(C0));
        for (int i = 0; i < H * V; i++) begin
            step(1'b1);
            chk_model("m1_f0");
        end
        Mode = 2'd2;
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                chk($sformatf("m1_y%0d_x%0d", y, x), 32'(video), 32'(line_m1[x]));
                chk_model("m1_f1");
                step(1'b1);
            end
        end

        // Mode 2: horizontal bars.
        Mode = 2'd3;
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                chk($sformatf("m2_y%0d_x%0d", y, x), 32'(video), 32'((y < 2) ? C0 : C1));
                chk_model("m2_f2");
                step(1'b1);
            end
        end

        // Mode 3: checkerboard, lines 2-3 inverted.
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                chk($sformatf("m3_y%0d_x%0d", y, x), 32'(video),
                    32'((y < 2) ? line_m3[x] : ((line_m3[x] == C0) ? C1 : C0)));
                chk($sformatf("m3_eol_y%0d_x%0d", y, x), 32'(EndOfLine), 32'(x == H - 1));
                chk_model("m3_f3");
                step(1'b1);
            end
        end

        // Mid-frame mode change at x=3,y=1 waits for the frame boundary.
        for (int i = 0; i < H + 3; i++) step(1'b1);
        Mode = 2'd0;
        while ((m_p % (H * V)) != 0) begin
            chk_model("midmode");
            step(1'b1);
        end
        chk("midmode_next_video", 32'(video), 32'(C2));
        chk("midmode_next_fc", 32'(FrameCount), 32'd5);
        for (int i = 0; i < 5; i++) step(1'b1);
        do_reset(2'd0);

        // Randomized stalls and mode changes.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) Mode = 2'($urandom_range(0, 3));
            step($urandom_range(0, 3) != 0);
            chk_model("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
